// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep capture engine.
// State encoding, MISR polynomial/seed and word-count helper.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    TT_IDLE  = 2'd0,
    TT_SWEEP = 2'd1,
    TT_DRAIN = 2'd2,
    TT_DONE  = 2'd3
  } tt_state_e;

  localparam logic [15:0] TT_MISR_POLY = 16'h1021;
  localparam logic [15:0] TT_MISR_SEED = 16'hFFFF;

  function automatic int tt_words(input int n_in, input int word_w);
    return (1 << n_in) / word_w;
  endfunction

endpackage

// File: rtl/tt_word_packer.sv
// Packs sampled response bits LSB-first into words and streams them
// out on a valid/ready port; reports free accumulation slots for issue.
module tt_word_packer
  import tt_sweep_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int AW     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     bit_v_i,
  input  logic                     bit_i,
  input  logic                     tt_ready_i,
  output logic [WORD_W-1:0]        tt_word_o,
  output logic [AW-1:0]            tt_addr_o,
  output logic                     tt_valid_o,
  output logic [$clog2(WORD_W):0]  free_o,
  output logic                     acc_empty_o
);

  localparam int LW = $clog2(WORD_W);
  localparam logic [LW:0] FULL = (LW+1)'(WORD_W);

  logic [WORD_W-1:0] acc_q, acc_d, acc_n;
  logic [WORD_W-1:0] out_q, out_d;
  logic [LW:0]       cnt_q, cnt_d, cnt_n;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     nxt_q, nxt_d;
  logic              val_q, val_d;
  logic              hs;
  logic              move;

  // Insert the new bit, then hand a full word to the output register
  // whenever that register is empty or is being drained this cycle.
  always_comb begin
    acc_n = acc_q;
    cnt_n = cnt_q;
    if (bit_v_i) begin
      acc_n[cnt_q[LW-1:0]] = bit_i;
      cnt_n = cnt_q + (LW+1)'(1);
    end
    hs     = val_q & tt_ready_i;
    move   = (cnt_n == FULL) & (~val_q | hs);
    val_d  = move | (val_q & ~hs);
    out_d  = move ? acc_n : out_q;
    addr_d = move ? nxt_q : addr_q;
    nxt_d  = move ? nxt_q + AW'(1) : nxt_q;
    acc_d  = move ? '0 : acc_n;
    cnt_d  = move ? '0 : cnt_n;
    if (clr_i) begin
      val_d  = 1'b0;
      out_d  = '0;
      addr_d = '0;
      nxt_d  = '0;
      acc_d  = '0;
      cnt_d  = '0;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      addr_q <= '0;
      nxt_q  <= '0;
      val_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      addr_q <= addr_d;
      nxt_q  <= nxt_d;
      val_q  <= val_d;
    end
  end

  assign tt_word_o   = out_q;
  assign tt_addr_o   = addr_q;
  assign tt_valid_o  = val_q;
  assign free_o      = FULL - cnt_q;
  assign acc_empty_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_capture.sv
// Exhaustive truth-table sweep: issues every input vector, samples y_in.
// Optional response MISR on sig_out when TT_SWEEP_SIGNATURE_EN is defined.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int N_IN     = 10,
  parameter int WORD_W   = 32,
  parameter int PIPE_LAT = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  output logic [N_IN-1:0]                   x_out,
  input  logic                              y_in,
  output logic [WORD_W-1:0]                 tt_word,
  output logic [N_IN-$clog2(WORD_W)-1:0]    tt_addr,
  output logic                              tt_valid,
  input  logic                              tt_ready,
  output logic                              busy,
  output logic                              done,
  output logic [N_IN:0]                     ones_cnt,
  output logic [15:0]                       sig_out
);

  localparam int LW = $clog2(WORD_W);
  localparam int AW = $clog2(tt_words(N_IN, WORD_W));

  tt_state_e       state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic [LW:0]     free;
  logic [LW:0]     tag_cnt;
  logic            acc_empty;
  logic            start_go;
  logic            clr;
  logic            last;
  logic            issue_ok;
  logic            iss;
  logic            samp_v;
  logic            samp_take;
  logic            drained;

  assign start_go  = (state_q == TT_IDLE) & start & ~abort;
  assign clr       = abort | start_go;
  assign last      = &idx_q;
  assign issue_ok  = ~tt_valid | (free > tag_cnt);
  assign iss       = (state_q == TT_SWEEP) & issue_ok & ~abort;
  assign samp_take = samp_v & ~abort;
  assign drained   = (tag_cnt == '0) & acc_empty
                   & (~tt_valid | tt_ready);

  if (PIPE_LAT == 0) begin : g_nolat
    assign samp_v  = iss;
    assign tag_cnt = '0;
  end else begin : g_lat
    logic [PIPE_LAT-1:0] tag_q, tag_d;

    // Shift issue tags so they line up with the delayed response.
    always_comb begin
      tag_d    = '0;
      tag_d[0] = iss;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
      if (clr) begin
        tag_d = '0;
      end
    end

    // Count tags still in flight, including the one landing now.
    always_comb begin
      tag_cnt = '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_cnt = tag_cnt + (LW+1)'(tag_q[i]);
      end
    end

    // Tag delay line register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_q <= '0;
      end else begin
        tag_q <= tag_d;
      end
    end

    assign samp_v = tag_q[PIPE_LAT-1];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; abort wins from every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TT_IDLE: begin
        if (start_go) begin
          state_d = TT_SWEEP;
        end
      end
      TT_SWEEP: begin
        if (abort) begin
          state_d = TT_IDLE;
        end else if (iss & last) begin
          state_d = TT_DRAIN;
        end
      end
      TT_DRAIN: begin
        if (abort) begin
          state_d = TT_IDLE;
        end else if (drained) begin
          state_d = TT_DONE;
        end
      end
      TT_DONE: begin
        state_d = TT_IDLE;
      end
      default: begin
        state_d = TT_IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      TT_SWEEP: busy = 1'b1;
      TT_DRAIN: busy = 1'b1;
      TT_DONE:  done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  // Issue index and onset count next-state.
  always_comb begin
    idx_d  = idx_q;
    ones_d = ones_q;
    if (start_go) begin
      idx_d  = '0;
      ones_d = '0;
    end else begin
      if (iss & ~last) begin
        idx_d = idx_q + N_IN'(1);
      end
      if (samp_take & y_in) begin
        ones_d = ones_q + (N_IN+1)'(1);
      end
    end
  end

  // Issue index and onset count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      ones_q <= '0;
    end else begin
      idx_q  <= idx_d;
      ones_q <= ones_d;
    end
  end

  assign x_out    = idx_q;
  assign ones_cnt = ones_q;

`ifdef TT_SWEEP_SIGNATURE_EN
  logic [15:0] sig_q, sig_d;
  logic        fb;

  // Galois MISR: shift in each sampled bit in vector order.
  always_comb begin
    sig_d = sig_q;
    fb    = sig_q[15] ^ y_in;
    if (start_go) begin
      sig_d = TT_MISR_SEED;
    end else if (samp_take) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (fb ? TT_MISR_POLY : 16'h0000);
    end
  end

  // MISR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= TT_MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_out = sig_q;
`else
  assign sig_out = 16'h0000;
`endif

  tt_word_packer #(
    .WORD_W (WORD_W),
    .AW     (AW)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .bit_v_i     (samp_take),
    .bit_i       (y_in),
    .tt_ready_i  (tt_ready),
    .tt_word_o   (tt_word),
    .tt_addr_o   (tt_addr),
    .tt_valid_o  (tt_valid),
    .free_o      (free),
    .acc_empty_o (acc_empty)
  );

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: table of sweeps plus abort/reset.
// Two instances: PIPE_LAT=0 and PIPE_LAT=2 (x9 through two registers).
module tb_tt_sweep_capture;

  typedef struct {
    int          dut;
    int          mode;
    int          stall;
    int          par;
    logic [31:0] lo;
    logic [31:0] hi;
    int          split;
    int          ones;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start, abort, ready;
  int   sel, mode;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        start0, start2, y0, y2, p1, p2;
  logic [9:0]  x0o, x2o;
  logic [31:0] w0, w2;
  logic [4:0]  a0, a2;
  logic        v0, v2, b0, b2, d0, d2;
  logic [10:0] o0, o2;
  logic [15:0] s0, s2;

  logic [9:0]  m_x;
  logic [31:0] m_w;
  logic [4:0]  m_a;
  logic        m_v, m_b, m_d;
  logic [10:0] m_o;
  logic [15:0] m_s;

  vec_t tbl[5];
  logic [15:0] sig_rst;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start0 = start & (sel == 0);
  assign start2 = start & (sel == 1);

  assign m_x = sel == 1 ? x2o : x0o;
  assign m_w = sel == 1 ? w2 : w0;
  assign m_a = sel == 1 ? a2 : a0;
  assign m_v = sel == 1 ? v2 : v0;
  assign m_b = sel == 1 ? b2 : b0;
  assign m_d = sel == 1 ? d2 : d0;
  assign m_o = sel == 1 ? o2 : o0;
  assign m_s = sel == 1 ? s2 : s0;

  always_comb begin
    case (mode)
      0:       y0 = x0o[0];
      1:       y0 = &x0o;
      2:       y0 = x0o[0] ^ x0o[5];
      3:       y0 = 1'b0;
      default: y0 = x0o[9];
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      p1 <= x2o[9];
      p2 <= p1;
    end
  end
  assign y2 = p2;

  tt_sweep_capture #(.N_IN(10), .WORD_W(32), .PIPE_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .x_out(x0o), .y_in(y0), .tt_word(w0), .tt_addr(a0),
    .tt_valid(v0), .tt_ready(ready), .busy(b0), .done(d0),
    .ones_cnt(o0), .sig_out(s0)
  );

  tt_sweep_capture #(.N_IN(10), .WORD_W(32), .PIPE_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
    .x_out(x2o), .y_in(y2), .tt_word(w2), .tt_addr(a2),
    .tt_valid(v2), .tt_ready(ready), .busy(b2), .done(d2),
    .ones_cnt(o2), .sig_out(s2)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] exp_word(input vec_t v, input int k);
    if (v.par != 0) return (k % 2 == 1) ? v.hi : v.lo;
    return (k < v.split) ? v.lo : v.hi;
  endfunction

  function automatic logic [15:0] misr_zero(input int n);
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = s[15];
      s  = {s[14:0], 1'b0};
      if (fb) s = s ^ 16'h1021;
    end
    return s;
  endfunction

  task automatic do_start(output int t);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = cyc;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, m_b, 0);
    chk({tag, "_valid"}, m_v, 0);
    chk({tag, "_x"}, m_x, 0);
    chk({tag, "_word"}, m_w, 0);
    chk({tag, "_addr"}, m_a, 0);
    chk({tag, "_done"}, m_d, 0);
    chk({tag, "_ones"}, m_o, 0);
    chk({tag, "_sig"}, m_s, sig_rst);
  endtask

  task automatic run_sweep(input int e);
    vec_t v;
    int   t, got, stall, phase, lat;
    logic done_seen;
    v = tbl[e];
    sel = v.dut;
    mode = v.mode;
    lat = (v.dut == 1) ? 2 : 0;
    ready = 1'b1;
    do_start(t);
    chk($sformatf("e%0d_busy_t1", e), m_b, 1);
    chk($sformatf("e%0d_x_t1", e), m_x, 0);
    got = 0;
    stall = 0;
    phase = 0;
    done_seen = 1'b0;
    for (int n = 0; n < 6000 && !done_seen; n++) begin
      if (m_d) begin
        done_seen = 1'b1;
        if (v.stall == 0)
          chk($sformatf("e%0d_done_cyc", e), cyc, t + 1025 + lat);
        chk($sformatf("e%0d_busy_done", e), m_b, 0);
      end else begin
        if (v.stall != 0) begin
          if (phase == 0 && m_v && m_a == 5'd3) phase = 1;
          if (phase == 1) begin
            if (stall < 100) begin
              ready = 1'b0;
              stall++;
              if (stall == 50 || stall == 100)
                chk($sformatf("e%0d_x_hold%0d", e, stall), m_x, 160);
            end else begin
              ready = 1'($urandom_range(0, 1));
            end
          end
        end
        if (m_v && ready) begin
          chk($sformatf("e%0d_addr%0d", e, got), m_a, got);
          chk($sformatf("e%0d_word%0d", e, got), m_w, exp_word(v, got));
          got++;
        end
        @(negedge clk);
      end
    end
    chk($sformatf("e%0d_done_seen", e), done_seen, 1);
    chk($sformatf("e%0d_nwords", e), got, 32);
    chk($sformatf("e%0d_ones", e), m_o, v.ones);
`ifdef TT_SWEEP_SIGNATURE_EN
    if (v.mode == 3 && v.dut == 0)
      chk($sformatf("e%0d_sig", e), m_s, misr_zero(1024));
`else
    chk($sformatf("e%0d_sig", e), m_s, 0);
`endif
    ready = 1'b1;
    @(negedge clk);
    chk($sformatf("e%0d_done_pulse", e), m_d, 0);
    chk($sformatf("e%0d_ones_hold", e), m_o, v.ones);
  endtask

  initial begin
    int   t;
    logic done_any;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b1;
    sel = 0;
    mode = 0;
`ifdef TT_SWEEP_SIGNATURE_EN
    sig_rst = 16'hFFFF;
`else
    sig_rst = 16'h0000;
`endif
    tbl[0] = '{0, 0, 0, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 32, 512};
    tbl[1] = '{0, 1, 0, 0, 32'h00000000, 32'h80000000, 31, 1};
    tbl[2] = '{0, 2, 1, 1, 32'hAAAAAAAA, 32'h55555555, 0, 512};
    tbl[3] = '{0, 3, 0, 0, 32'h00000000, 32'h00000000, 32, 0};
    tbl[4] = '{1, 3, 0, 0, 32'h00000000, 32'hFFFFFFFF, 16, 512};

    #3;
    check_reset("rst0");
    sel = 1;
    check_reset("rst2");
    sel = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int e = 0; e < 5; e++) run_sweep(e);

    sel = 0;
    mode = 0;
    ready = 1'b1;
    do_start(t);
    for (int n = 0; n < 600 && cyc < t + 499; n++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", m_b, 0);
    chk("abort_valid", m_v, 0);
    chk("abort_ones", m_o, 249);
    done_any = 1'b0;
    for (int n = 0; n < 1100; n++) begin
      if (m_d) done_any = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", done_any, 0);
    chk("abort_ones_frozen", m_o, 249);
    run_sweep(0);

    sel = 0;
    mode = 0;
    do_start(t);
    repeat (300) @(negedge clk);
    chk("midrst_busy_before", m_b, 1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Exhaustive truth-table capture engine for the single-output benchmark netlists (10 inputs `x0..x9`, output `y0`). It drives every input vector in ascending order into the combinational or registered netlist under test and samples the `y0` response. The sampled bits are packed into addressed words on a valid/ready stream and the onset count is accumulated. It sits on the evaluation side of the benchmark harness: the netlist writes `y0`, and this block reads it back as a truth table.

## Interface
Parameters:
- `N_IN`, 10, number of netlist inputs; 2^`N_IN` vectors are swept.
- `WORD_W`, 32, packed word width; must divide 2^`N_IN`.
- `PIPE_LAT`, 0, register stages between `x_out` and `y_in` in the netlist under test (0 to 4).

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1, rising-edge clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, begins a sweep when sampled high in IDLE.
- `abort`, in, 1, synchronous cancel; takes priority over `start`.
- `x_out`, out, `N_IN`, vector driven to the netlist; `x_out[i]` is index bit i (`x0` is the LSB).
- `y_in`, in, 1, netlist response.
- `tt_word`, out, `WORD_W`, packed response word.
- `tt_addr`, out, `N_IN`-log2(`WORD_W`), word index.
- `tt_valid`, out, 1, word available.
- `tt_ready`, in, 1, consumer accepts the word.
- `busy`, out, 1, high in SWEEP and DRAIN.
- `done`, out, 1, one-cycle pulse at completion.
- `ones_cnt`, out, `N_IN`+1, count of sampled 1s.
- `sig_out`, out, 16, response signature (see Configuration).

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
  - IDLE: on `start`, go to SWEEP. This clears `ones_cnt`, the issue index and the packer, and seeds the signature.
  - SWEEP: issue vectors 0 to 2^`N_IN`-1. After the last vector is issued, go to DRAIN.
  - DRAIN: wait for all in-flight samples and the last word handshake, then go to DONE.
  - DONE: one cycle with `done`=1, then return to IDLE.
- `start` in any state other than IDLE is ignored.
- `abort` in any state: go to IDLE on the next edge. In-flight samples and the pending word are discarded, and `tt_valid` drops. `ones_cnt` and `sig_out` freeze.
- Issue: `x_out` advances by one per cycle when issue is allowed, and holds otherwise.
- Sampling: a valid-tag delay line of depth `PIPE_LAT` marks each cycle where `y_in` corresponds to an issued vector. With `PIPE_LAT`=0, `y_in` is sampled at the end of the cycle in which its vector is on `x_out`.
- Packing: bit j of word k equals f(vector k·`WORD_W`+j).
  - The accumulation register fills from LSB upward.
  - When full, it moves into the output register (`tt_valid`=1, `tt_addr`=k).
- Issue is allowed when the output register is empty, or when the accumulation free slots exceed the number of in-flight samples. This guarantees no sample is ever dropped under backpressure.
- Handshake: the word transfers on `tt_valid`&`tt_ready`. While `tt_valid` is high, `tt_word` and `tt_addr` hold stable.
- `ones_cnt` increments for each sampled 1. Final value range is 0..2^`N_IN`.

## Timing
- Reset values: state=IDLE, `x_out`=0, `tt_word`=0, `tt_addr`=0, `tt_valid`=0, `busy`=0, `done`=0, `ones_cnt`=0, `sig_out`=0xFFFF (0 when the feature is compiled out).
- `start` is sampled at edge t. `x_out`=0 and `busy`=1 from cycle t+1.
- With `tt_ready` held high and `PIPE_LAT`=P:
  - Word k is valid starting at cycle t+1+(k+1)·`WORD_W`+P.
  - Each word is accepted in its first valid cycle.
  - For defaults, the last word is valid at t+1025. `done` pulses at t+1026 and `busy` falls at the same cycle.
- `ones_cnt` and `sig_out` are final and stable when `done` is high, and hold until the next `start`.
- Reset mid-sweep clears everything asynchronously. No partial word is emitted.

## Configuration
- `TT_SWEEP_SIGNATURE_EN` defined:
  - A 16-bit Galois MISR with polynomial x^16+x^12+x^5+1 and seed 0xFFFF is enabled.
  - It shifts in each sampled bit in vector order and its state is driven on `sig_out`.
- Undefined: `sig_out` is tied to 0 and no MISR logic is present. The port list is unchanged.

## Structure
- Package `tt_sweep_pkg`:
  - State enum `tt_state_e`.
  - Constants `TT_MISR_POLY`=16'h1021 and `TT_MISR_SEED`=16'hFFFF.
  - Function `tt_words(n_in, word_w)` returning the word count.
- One sub-module, `tt_word_packer`. It holds the accumulation register, the output register with valid/ready, the address counter and the free-slot count used by the issue check.
- The top level holds the FSM, the issue counter, the tag delay line, `ones_cnt` and the MISR.

## Test plan
- `y_in`=`x0`, `PIPE_LAT`=0, ready always high: 32 words, all 0xAAAAAAAA, addr 0..31; `ones_cnt`=512; `done` at t+1026.
- `y_in`=AND of all inputs: words 0..30 are 0, word 31 is 0x80000000; `ones_cnt`=1.
- `y_in`=`x9` through 2 registers, `PIPE_LAT`=2: words 0..15 are 0x00000000, words 16..31 are 0xFFFFFFFF; `ones_cnt`=512.
- `y_in`=`x0`^`x5`, `tt_ready` low for 100 cycles while word 3 is pending, then random: `x_out` holds during the stall; all 32 words are correct and in order; no duplicates or drops.
- `abort` at cycle t+500: IDLE next cycle, `tt_valid`=0, no `done`. A following `start` yields a full correct sweep. `rst_n` low mid-sweep: all outputs return to reset values immediately.
- With `TT_SWEEP_SIGNATURE_EN`, `y_in`=0: `sig_out` equals the model MISR after 1024 zero shifts from 0xFFFF. Without the macro, `sig_out`=0 throughout.
